// File: rtl/pll_dyn_ctrl_pkg.sv
// Shared types and constants for the Gowin rPLL dynamic divider controller.
package pll_dyn_ctrl_pkg;

  localparam int unsigned DselW = 6;
  localparam int unsigned ModeW = 3;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelease,
    StRun,
    StError
  } state_e;

  // LSB of divider set `idx` inside a packed NUM_MODES*DselW table parameter.
  function automatic int unsigned tbl_lsb(input logic [ModeW-1:0] idx);
    return 32'(idx) * DselW;
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Mode request handshake between a requester and the PLL controller.
interface pll_dyn_ctrl_if;
  import pll_dyn_ctrl_pkg::*;

  logic             mode_req;
  logic [ModeW-1:0] mode_sel;
  logic             mode_ack;
  logic             busy;

  modport master (output mode_req, output mode_sel, input mode_ack, input busy);
  modport slave  (input mode_req, input mode_sel, output mode_ack, output busy);
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for PLL LOCK plus a consecutive-high-cycle qualifier.
module pll_lock_sync #(
  parameter int unsigned StableCyc = 1024,
  parameter int unsigned CntW      = 11
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic lock_i,
  output logic lock_s_o,
  output logic lock_stable_o
);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], lock_i};
    cnt_d  = cnt_q;
    if (clr_i || !sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(StableCyc)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_s_o      = sync_q[1];
  assign lock_stable_o = (cnt_q == CntW'(StableCyc));

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Runtime controller for a Gowin rPLL: divider table, PLL reset/lock sequencing and
// staged release of downstream resets. Clocked from the free-running reference clock.
module pll_dyn_ctrl
  import pll_dyn_ctrl_pkg::*;
#(
  parameter int unsigned                NUM_MODES        = 4,
  parameter logic [NUM_MODES*DselW-1:0] MODE_IDIV        = {6'd3, 6'd0, 6'd1, 6'd2},
  parameter logic [NUM_MODES*DselW-1:0] MODE_FBDIV       = {6'd24, 6'd19, 6'd29, 6'd15},
  parameter logic [NUM_MODES*DselW-1:0] MODE_ODIV        = {6'd8, 6'd2, 6'd8, 6'd4},
  parameter int unsigned                NUM_DOMAINS      = 3,
  parameter int unsigned                PLL_RST_CYCLES   = 16,
  parameter int unsigned                LOCK_STABLE_CYC  = 1024,
  parameter int unsigned                LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned                STAGE_GAP_CYC    = 64,
  parameter int unsigned                MAX_RETRY        = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_lock,
  pll_dyn_ctrl_if.slave          mode_if,
  output logic                   pll_reset,
  output logic [DselW-1:0]       idsel,
  output logic [DselW-1:0]       fbdsel,
  output logic [DselW-1:0]       odsel,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   locked,
  output logic                   err_timeout
);

  localparam int unsigned MaxAB  = (PLL_RST_CYCLES > STAGE_GAP_CYC) ?
                                   PLL_RST_CYCLES : STAGE_GAP_CYC;
  localparam int unsigned MaxCD  = (LOCK_STABLE_CYC > LOCK_TIMEOUT_CYC) ?
                                   LOCK_STABLE_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1) + 1;
  localparam int unsigned DomW   = $clog2(NUM_DOMAINS + 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CntW-1:0]        timer_q, timer_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic [DomW-1:0]        idx_q, idx_d;
  logic [ModeW-1:0]       cur_mode_q, cur_mode_d;
  logic                   ack_pend_q, ack_pend_d;
  logic                   pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   locked_q, locked_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   ack_q, ack_d;
  logic [DselW-1:0]       idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic                   lock_s, lock_stable;
  logic                   req_ok, restart;

  pll_lock_sync #(
    .StableCyc (LOCK_STABLE_CYC),
    .CntW      (CntW)
  ) u_lock_sync (
    .clk_i         (clk),
    .reset_i       (reset),
    .clr_i         (state_q == StPllRst),
    .lock_i        (pll_lock),
    .lock_s_o      (lock_s),
    .lock_stable_o (lock_stable)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    idx_d      = idx_q;
    cur_mode_d = cur_mode_q;
    ack_pend_d = ack_pend_q;
    rst_out_d  = rst_out_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    restart    = 1'b0;
    req_ok     = mode_if.mode_req && (32'(mode_if.mode_sel) < NUM_MODES);

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
          state_d = StWaitLock;
          timer_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (timer_q != CntW'(LOCK_TIMEOUT_CYC)) timer_d = timer_q + 1'b1;
        if (lock_s) begin
          state_d = StStable;
        end else if (timer_q >= CntW'(LOCK_TIMEOUT_CYC - 1)) begin
          cnt_d = '0;
          if (retry_q == RetryW'(MAX_RETRY)) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StPllRst;
          end
        end
      end
      StStable: begin
        // Timer keeps running so a flapping lock still hits the per-attempt timeout.
        if (timer_q != CntW'(LOCK_TIMEOUT_CYC)) timer_d = timer_q + 1'b1;
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (lock_stable) begin
          state_d   = StRelease;
          rst_out_d = rst_out_q & ~NUM_DOMAINS'(1);
          idx_d     = DomW'(1);
          cnt_d     = '0;
        end
      end
      StRelease: begin
        if (!lock_s) begin
          restart = 1'b1;
        end else if (idx_q == DomW'(NUM_DOMAINS)) begin
          state_d    = StRun;
          ack_d      = ack_pend_q;
          ack_pend_d = 1'b0;
        end else if (cnt_q == CntW'(STAGE_GAP_CYC - 1)) begin
          rst_out_d = rst_out_q & ~(NUM_DOMAINS'(1) << idx_q);
          idx_d     = idx_q + 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) restart = 1'b1;
      end
      StError: ;
      default: state_d = StPllRst;
    endcase

    // An accepted request overrides a simultaneous lock loss.
    if ((state_q == StRun || state_q == StError) && req_ok) begin
      cur_mode_d = mode_if.mode_sel;
      ack_pend_d = 1'b1;
      err_d      = 1'b0;
      ack_d      = 1'b0;
      restart    = 1'b1;
    end

    if (restart) begin
      state_d   = StPllRst;
      cnt_d     = '0;
      retry_d   = '0;
      rst_out_d = '1;
    end

    if (state_d == StError) rst_out_d = '1;
    pll_reset_d = (state_d == StPllRst);
    locked_d    = (state_d == StRun);
    busy_d      = !(state_d inside {StRun, StError});
    idsel_d     = ~MODE_IDIV[tbl_lsb(cur_mode_d) +: DselW];
    fbdsel_d    = ~MODE_FBDIV[tbl_lsb(cur_mode_d) +: DselW];
    odsel_d     = ~MODE_ODIV[tbl_lsb(cur_mode_d) +: DselW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      idx_q       <= '0;
      cur_mode_q  <= '0;
      ack_pend_q  <= 1'b0;
      pll_reset_q <= 1'b1;
      rst_out_q   <= '1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      idsel_q     <= ~MODE_IDIV[DselW-1:0];
      fbdsel_q    <= ~MODE_FBDIV[DselW-1:0];
      odsel_q     <= ~MODE_ODIV[DselW-1:0];
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      cur_mode_q  <= cur_mode_d;
      ack_pend_q  <= ack_pend_d;
      pll_reset_q <= pll_reset_d;
      rst_out_q   <= rst_out_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
    end
  end

  assign pll_reset        = pll_reset_q;
  assign rst_out          = rst_out_q;
  assign locked           = locked_q;
  assign err_timeout      = err_q;
  assign idsel            = idsel_q;
  assign fbdsel           = fbdsel_q;
  assign odsel            = odsel_q;
  assign mode_if.mode_ack = ack_q;
  assign mode_if.busy     = busy_q;

endmodule
